processing_unit: RTL and testbench
==================================

# processing_unit

Datapath stage of the 8-bit accumulator CPU, driven directly by `Control_Unit`. It holds the accumulator, the operand register R1 and the carry flag, and contains the UAL (ALU). It executes the `sel_UAL` operation selected by the control unit and returns the registered `carry` flag to it. It presents the accumulator as write data to memory and takes memory read data into R1.

## Interface

- `DATA_W`, default 8: datapath width. Only 8 is verified.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ce` input 1: clock enable. No register changes while low, except under reset.
- `data_in` input DATA_W: memory read data (operand or instruction-fetched value).
- `sel_UAL` input 3: UAL operation select. Codes are listed under Operation.
- `load_R1` input 1: R1 <= `data_in`.
- `load_accu` input 1: accu <= UAL result.
- `load_carry` input 1: carry <= UAL carry-out.
- `clear_carry` input 1: carry <= 0.
- `data_out` output DATA_W: accumulator value, used as memory write data.
- `carry` output 1: registered carry flag, fed to `Control_Unit.carry`.
- `ual_res` output DATA_W: combinational UAL result, for debug and observation only.

## Operation

- State: `accu[DATA_W-1:0]`, `r1[DATA_W-1:0]`, `carry_q`. All are 0 after reset.
- UAL operands: A = accu, B = r1, both the pre-edge register values. The UAL produces `res` and `cout`.
  - 000 PASSA: res = A; cout = 0.
  - 001 ADD: {cout,res} = A + B, computed DATA_W+1 bits wide.
  - 010 SUB: res = A − B mod 2^DATA_W; cout = 1 when A ≥ B (no borrow).
  - 011 NOR: res = ~(A|B); cout = 0.
  - 100 AND; 101 OR; 110 XOR: bitwise; cout = 0.
  - 111 PASSB: res = B; cout = 0.
- Register update rules, applied at a rising edge when `rst`=0 and `ce`=1:
  - `load_R1`: r1 <= `data_in`.
  - `load_accu`: accu <= res.
  - `clear_carry`: carry_q <= 0. This has priority over `load_carry`.
  - `load_carry` (with `clear_carry`=0): carry_q <= cout.
  - Any register whose strobe is low holds its value.
- Simultaneous strobes:
  - `load_R1` with `load_accu`: accu uses the old r1, and r1 takes `data_in`.
  - `load_accu` with `load_carry`: both take results from the same UAL evaluation.
- Reset:
  - `rst`=1 at an edge clears accu, r1 and carry_q, regardless of `ce` and all strobes.
  - Reset mid-instruction discards any pending strobes. The first cycle after reset shows `data_out`=0, `carry`=0.
- `ce`=0: all strobes are ignored and the state is frozen. The combinational `ual_res` still follows `sel_UAL`.

## Timing

- `data_out` = accu and `carry` = carry_q are direct register outputs. Both update one cycle after the strobe edge.
- `ual_res` is combinational from accu, r1 and `sel_UAL`, with zero cycle latency.
- Memory read data must be valid at the edge where `load_R1`=1, in the same cycle as the strobe. R1 is usable by the UAL from the next cycle.
- Back-to-back operations:
  - An operation in cycle n+1 sees the accu written in cycle n.
  - A result can be stored (`data_out`) in the cycle right after `load_accu`.
- Throughput: one UAL operation per enabled cycle. There are no stalls or handshakes; sequencing is the control unit's job.

## Structure

- Package `processing_unit_pkg`:
  - `DATA_W` default.
  - `ual_op_t` enum (3-bit) with the codes PASSA, ADD, SUB, NOR, AND, OR, XOR, PASSB.
  - Shared with `Control_Unit` so both blocks use the same opcode encoding.
- Sub-module `ual`:
  - Purely combinational.
  - Ports: A, B, op, res, cout.
  - Tested standalone as well.
- Top `processing_unit`:
  - Instantiates `ual`.
  - Contains the three registers with their enable and priority logic.

## Test plan

- Reset and enable:
  - Drive strobes with `ce`=0 → all registers frozen.
  - Assert `rst`=1 with `ce`=0 → `data_out`=0x00 and `carry`=0 next cycle.
- ADD with carry:
  - r1=0x01, accu=0xFF, ADD with `load_accu`+`load_carry` → `data_out`=0x00, `carry`=1.
  - Then PASSA with `load_carry` → `carry`=0.
- SUB borrow:
  - accu=0x10, r1=0x20, SUB → `data_out`=0xF0, `carry`=0.
  - accu=0x20, r1=0x20 → 0x00, `carry`=1.
- Simultaneous strobes:
  - r1=0x05, accu=0x03, `data_in`=0x80, ADD with `load_R1`+`load_accu` → accu=0x08, r1=0x80.
  - `load_carry`+`clear_carry` on a carry-producing ADD → `carry`=0.
- Logic ops sweep:
  - accu=0xAA, r1=0x0F through NOR/AND/OR/XOR/PASSB → 0x50/0x0A/0xAF/0xA5/0x0F, `carry`=0 each time.
- Reset mid-operation:
  - Assert `rst` in the same cycle as `load_accu`+`load_carry` on an ADD with 0xFF+0x01 → accu=0x00, `carry`=0, r1=0x00.
  - Random sequence versus a reference model afterwards, 10k cycles, no mismatch.

Source files
------------

// File: rtl/processing_unit_pkg.sv
// Shared definitions for the accumulator CPU datapath: default width and the UAL opcode encoding.
// Control_Unit imports this package, so both blocks decode the same opcodes.
package processing_unit_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    PASSA = 3'b000,
    ADD   = 3'b001,
    SUB   = 3'b010,
    NOR   = 3'b011,
    AND   = 3'b100,
    OR    = 3'b101,
    XOR   = 3'b110,
    PASSB = 3'b111
  } ual_op_t;

endpackage

// File: rtl/processing_unit_ual.sv
// Combinational UAL (ALU): A op B -> res, with carry-out for ADD and not-borrow for SUB.
module ual #(
  parameter int unsigned DATA_W = processing_unit_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] res,
  output logic              cout
);
  import processing_unit_pkg::*;

  ual_op_t         op_e;
  logic [DATA_W:0] sum;

  assign op_e = ual_op_t'(op);

  always_comb begin
    sum  = '0;
    res  = '0;
    cout = 1'b0;
    case (op_e)
      PASSA: res = A;
      ADD: begin
        sum  = {1'b0, A} + {1'b0, B};
        res  = sum[DATA_W-1:0];
        cout = sum[DATA_W];
      end
      SUB: begin
        res  = A - B;
        // cout reads as "no borrow"
        cout = (A >= B);
      end
      NOR:     res = ~(A | B);
      AND:     res = A & B;
      OR:      res = A | B;
      XOR:     res = A ^ B;
      PASSB:   res = B;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/processing_unit.sv
// Datapath stage: accumulator, operand register R1, carry flag and the UAL they feed.
module processing_unit #(
  parameter int unsigned DATA_W = processing_unit_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        sel_UAL,
  input  logic              load_R1,
  input  logic              load_accu,
  input  logic              load_carry,
  input  logic              clear_carry,
  output logic [DATA_W-1:0] data_out,
  output logic              carry,
  output logic [DATA_W-1:0] ual_res
);
  import processing_unit_pkg::*;

  logic [DATA_W-1:0] accu_d, accu_q;
  logic [DATA_W-1:0] r1_d, r1_q;
  logic              carry_d, carry_q;
  logic [DATA_W-1:0] res;
  logic              cout;

  ual #(
    .DATA_W(DATA_W)
  ) u_ual (
    .A   (accu_q),
    .B   (r1_q),
    .op  (sel_UAL),
    .res (res),
    .cout(cout)
  );

  always_comb begin
    accu_d  = accu_q;
    r1_d    = r1_q;
    carry_d = carry_q;
    if (ce) begin
      if (load_R1)   r1_d   = data_in;
      if (load_accu) accu_d = res;
      if (clear_carry) begin
        carry_d = 1'b0;
      end else if (load_carry) begin
        carry_d = cout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accu_q  <= '0;
      r1_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      accu_q  <= accu_d;
      r1_q    <= r1_d;
      carry_q <= carry_d;
    end
  end

  assign data_out = accu_q;
  assign carry    = carry_q;
  assign ual_res  = res;

endmodule

// File: tb/tb_processing_unit.sv
// Directed-vector bench for processing_unit, followed by a seeded random run against a small model.
module tb_processing_unit;
  import processing_unit_pkg::*;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [7:0] data_in;
  logic [2:0] sel_UAL;
  logic       load_R1;
  logic       load_accu;
  logic       load_carry;
  logic       clear_carry;
  logic [7:0] data_out;
  logic       carry;
  logic [7:0] ual_res;

  int unsigned vec_cnt;
  int unsigned miss_cnt;

  processing_unit #(
    .DATA_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .data_in    (data_in),
    .sel_UAL    (sel_UAL),
    .load_R1    (load_R1),
    .load_accu  (load_accu),
    .load_carry (load_carry),
    .clear_carry(clear_carry),
    .data_out   (data_out),
    .carry      (carry),
    .ual_res    (ual_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic c, input logic r, input logic [7:0] din, input logic [2:0] op,
                      input logic lr1, input logic la, input logic lc, input logic cc);
    ce          = c;
    rst         = r;
    data_in     = din;
    sel_UAL     = op;
    load_R1     = lr1;
    load_accu   = la;
    load_carry  = lc;
    clear_carry = cc;
    @(posedge clk);
    #1;
  endtask

  // accu <= a, r1 <= b, carry untouched.
  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    step(1'b1, 1'b0, a,     PASSA, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, PASSB, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, b,     PASSA, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic peek_r1(input string tag, input logic [7:0] exp);
    sel_UAL = PASSB;
    #1;
    chk(tag, ual_res, exp);
  endtask

  function automatic logic [8:0] ual_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] r;
    case (op)
      3'd0:    r = {1'b0, a};
      3'd1:    r = {1'b0, a} + {1'b0, b};
      3'd2:    r = {(a >= b), 8'(a - b)};
      3'd3:    r = {1'b0, ~(a | b)};
      3'd4:    r = {1'b0, a & b};
      3'd5:    r = {1'b0, a | b};
      3'd6:    r = {1'b0, a ^ b};
      default: r = {1'b0, b};
    endcase
    return r;
  endfunction

  initial begin
    logic [2:0] sweep_op  [5];
    logic [7:0] sweep_exp [5];
    logic [7:0] m_accu, m_r1;
    logic       m_carry;
    logic [8:0] m_out;
    vec_cnt  = 0;
    miss_cnt = 0;

    // Reset
    step(1'b1, 1'b1, 8'h00, PASSA, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_data_out", data_out, 8'h00);
    chk("reset_carry", {7'b0, carry}, 8'h00);
    peek_r1("reset_r1", 8'h00);

    // ADD with carry, then PASSA clears it via load_carry
    load_ab(8'hFF, 8'h01);
    step(1'b1, 1'b0, 8'h00, ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("add_ff01_res", data_out, 8'h00);
    chk("add_ff01_carry", {7'b0, carry}, 8'h01);
    step(1'b1, 1'b0, 8'h00, PASSA, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("passa_carry", {7'b0, carry}, 8'h00);

    // ce=0 freezes everything; ual_res stays combinational
    load_ab(8'hFF, 8'h01);
    step(1'b1, 1'b0, 8'h00, ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h55, ADD, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("ce0_data_out", data_out, 8'hFF);
    chk("ce0_carry", {7'b0, carry}, 8'h01);
    chk("ce0_ual_add", ual_res, 8'h00);
    peek_r1("ce0_r1", 8'h01);

    // Reset wins over ce=0
    step(1'b0, 1'b1, 8'h55, ADD, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_ce0_data_out", data_out, 8'h00);
    chk("rst_ce0_carry", {7'b0, carry}, 8'h00);
    peek_r1("rst_ce0_r1", 8'h00);

    // SUB: borrow, then equal operands
    load_ab(8'h10, 8'h20);
    step(1'b1, 1'b0, 8'h00, SUB, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sub_1020_res", data_out, 8'hF0);
    chk("sub_1020_carry", {7'b0, carry}, 8'h00);
    load_ab(8'h20, 8'h20);
    step(1'b1, 1'b0, 8'h00, SUB, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("sub_2020_res", data_out, 8'h00);
    chk("sub_2020_carry", {7'b0, carry}, 8'h01);

    // load_R1 + load_accu: accu sees old r1
    load_ab(8'h03, 8'h05);
    step(1'b1, 1'b0, 8'h80, ADD, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("simul_accu", data_out, 8'h08);
    peek_r1("simul_r1", 8'h80);
    chk("simul_carry_hold", {7'b0, carry}, 8'h01);

    // clear_carry beats load_carry on a carry-producing ADD
    load_ab(8'hFF, 8'h01);
    step(1'b1, 1'b0, 8'h00, ADD, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_prio_carry", {7'b0, carry}, 8'h00);
    chk("clr_prio_accu", data_out, 8'hFF);

    // Logic sweep, with carry preset to 1 so the clear is visible
    sweep_op  = '{NOR, AND, OR, XOR, PASSB};
    sweep_exp = '{8'h50, 8'h0A, 8'hAF, 8'hA5, 8'h0F};
    for (int i = 0; i < 5; i++) begin
      load_ab(8'hFF, 8'h01);
      step(1'b1, 1'b0, 8'h00, ADD, 1'b0, 1'b0, 1'b1, 1'b0);
      load_ab(8'hAA, 8'h0F);
      step(1'b1, 1'b0, 8'h00, sweep_op[i], 1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("logic_op%0d_res", sweep_op[i]), data_out, sweep_exp[i]);
      chk($sformatf("logic_op%0d_carry", sweep_op[i]), {7'b0, carry}, 8'h00);
    end

    // Reset in the same cycle as a carry-producing ADD with strobes
    load_ab(8'hFF, 8'h01);
    step(1'b1, 1'b1, 8'h00, ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_mid_accu", data_out, 8'h00);
    chk("rst_mid_carry", {7'b0, carry}, 8'h00);
    peek_r1("rst_mid_r1", 8'h00);

    // Random run against the reference model, starting from the reset state
    m_accu  = 8'h00;
    m_r1    = 8'h00;
    m_carry = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      ce          = ($urandom_range(3) != 0);
      rst         = ($urandom_range(63) == 0);
      data_in     = 8'($urandom);
      sel_UAL     = 3'($urandom);
      load_R1     = 1'($urandom);
      load_accu   = 1'($urandom);
      load_carry  = 1'($urandom);
      clear_carry = ($urandom_range(3) == 0);
      #1;
      m_out = ual_ref(sel_UAL, m_accu, m_r1);
      chk("rand_ual_res", ual_res, m_out[7:0]);
      if (rst) begin
        m_accu  = 8'h00;
        m_r1    = 8'h00;
        m_carry = 1'b0;
      end else if (ce) begin
        if (load_accu) m_accu = m_out[7:0];
        if (load_R1) m_r1 = data_in;
        if (clear_carry) m_carry = 1'b0;
        else if (load_carry) m_carry = m_out[8];
      end
      @(posedge clk);
      #1;
      chk("rand_data_out", data_out, m_accu);
      chk("rand_carry", {7'b0, carry}, {7'b0, m_carry});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
